fp32_result_uart_tx: RTL and testbench
======================================

Name: fp32_result_uart_tx

Overview:
Output end of the FP32 MAC datapath. It accepts one 32-bit FP32 MAC result over a valid/ready handshake. It serialises the result as four UART 8N1 frames on a single TX line toward the host. It is the transmit counterpart of the operand receive path feeding the MAC, and it closes the rx -> mac -> tx loop.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range >= 2.
MSB_BYTE_FIRST, 1, 1 sends bytes [31:24],[23:16],[15:8],[7:0]; 0 sends the reverse order.

Ports:
CLK_I  input  1  system clock; all logic is on the rising edge.
RSTL_I  input  1  reset, synchronous, active-low.
MAC_DELTA_I  input  32  FP32 result from the MAC.
MAC_VALID_I  input  1  result on MAC_DELTA_I is valid.
MAC_READY_O  output  1  block can accept a result.
TX_O  output  1  UART serial line; idles high.
TX_BUSY_O  output  1  a word is being serialised.
DONE_O  output  1  one-cycle pulse when the last stop bit of the word completes.

Behaviour:
- Reset is synchronous: RSTL_I=0 sampled at a rising edge forces the following.
  - TX_O=1, MAC_READY_O=1, TX_BUSY_O=0, DONE_O=0.
  - FSM=IDLE; bit counter, baud counter and byte index all 0.
- Reset mid-frame: the line returns high at the next edge, the word is discarded, and DONE_O is not pulsed.
- Handshake:
  - A transfer occurs at an edge where MAC_VALID_I=1 and MAC_READY_O=1.
  - MAC_DELTA_I is captured into a 32-bit holding register.
  - MAC_READY_O drops and TX_BUSY_O rises at that same edge.
  - While busy, MAC_VALID_I is ignored. The source must hold its result until ready; changes on MAC_DELTA_I while busy have no effect.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START on a transfer.
  - START: TX_O=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: 8 bits, LSB first, each held for CLKS_PER_BIT cycles; bit index 0..7. After bit 7 -> STOP.
  - STOP: TX_O=1 for CLKS_PER_BIT cycles. Then, if byte index < 3: increment byte index, -> START (no idle gap between bytes). If byte index = 3: -> IDLE.
- Timing, with the transfer at edge k and N=CLKS_PER_BIT:
  - TX_O=0 during cycles k+1..k+N.
  - Each frame is 10N cycles; the word is 40N cycles.
  - In cycle k+40N+1: DONE_O=1 (single cycle), MAC_READY_O=1, TX_BUSY_O=0.
- Back-to-back words: a transfer accepted in the DONE_O cycle starts its start bit at the next cycle. Minimum word period is 40N+1 cycles.
- Byte selection: MSB_BYTE_FIRST selects byte order from the holding register. Bit order within a byte is always LSB first.
- Baud counter:
  - Width is $clog2(CLKS_PER_BIT); counts 0..N-1 and wraps.
  - Bit and state advance only on the wrap cycle.
  - Bit index wraps 7->0 and byte index wraps 3->0; neither may overflow into undefined states.
- Illegal or default FSM encoding -> IDLE with TX_O=1.
- All outputs are registered; TX_O has no combinational path from inputs.

Decomposition:
- Package fp32_tx_pkg holds:
  - the state enum (IDLE, START, DATA, STOP);
  - UART_DATA_BITS=8, BYTES_PER_WORD=4, UART_IDLE_LEVEL=1'b1.
- Natural sub-module: uart_byte_tx. It has a byte-level valid/ready input and produces an 8N1 frame on TX_O.
- fp32_result_uart_tx then keeps the word handshake, holding register, byte index/selection and DONE_O. Counters and the START/DATA/STOP sequencing live in uart_byte_tx.

Test Plan:
- CLKS_PER_BIT=4, MSB_BYTE_FIRST=1. Send 0x3FC00000 (1.5) -> line decodes 0x3F, 0xC0, 0x00, 0x00. DONE_O pulses exactly at k+161. MAC_READY_O is low during k+1..k+160.
- Hold MAC_VALID_I=1 continuously with 0x40490FDB, then 0xC0000000 -> second start bit at k+162; bytes 40 49 0F DB then C0 00 00 00; no gap and no dropped word.
- While busy, toggle MAC_DELTA_I to 0xFFFFFFFF with MAC_VALID_I=1 -> transmitted bytes are unchanged; no second DONE_O until re-accepted.
- MSB_BYTE_FIRST=0, send 0x12345678 -> bytes 0x78, 0x56, 0x34, 0x12. Each first data bit equals the byte LSB.
- Assert RSTL_I=0 for one cycle during DATA of byte 2 -> TX_O=1, MAC_READY_O=1 at the next edge. No DONE_O. The next accepted word transmits cleanly from byte 0.
- After reset with no valid input -> TX_O stays 1 and TX_BUSY_O stays 0 for 1000 cycles.

Source files
------------

// File: rtl/fp32_tx_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : fp32_tx_pkg                                                   |
// | Description : Shared types and constants for the FP32 result UART          |
// |               transmitter: FSM state encoding, frame geometry and a byte   |
// |               lane selection helper.                                        |
// | Ports       : none (package)                                                |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
package fp32_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  localparam int   UART_DATA_BITS  = 8;
  localparam int   BYTES_PER_WORD  = 4;
  localparam logic UART_IDLE_LEVEL = 1'b1;

  // Byte idx is the transmission slot (0 = first byte on the line). With
  // msb_first set, slot 0 is the most significant lane of the word.
  function automatic logic [UART_DATA_BITS-1:0] select_byte(
    input logic [31:0] word,
    input logic [1:0]  idx,
    input logic        msb_first
  );
    logic [1:0] lane;
    lane = msb_first ? (2'd3 - idx) : idx;
    case (lane)
      2'd0:    return word[7:0];
      2'd1:    return word[15:8];
      2'd2:    return word[23:16];
      default: return word[31:24];
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_byte_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : uart_byte_tx                                                  |
// | Description : 8N1 UART byte serialiser with a byte-level valid/ready input. |
// |               A new byte may be accepted on the last cycle of a stop bit,  |
// |               so consecutive frames follow with no idle gap.               |
// | Ports       : i_clk        - system clock, rising edge                     |
// |               i_rst_n      - synchronous active-low reset                  |
// |               i_data[7:0]  - byte to send                                  |
// |               i_valid      - i_data is valid                               |
// |               o_ready      - byte accepted at this edge if i_valid         |
// |               o_stop_end   - current cycle is the final stop-bit cycle     |
// |               o_tx         - registered serial line, idles high            |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module uart_byte_tx
  import fp32_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [UART_DATA_BITS-1:0] i_data,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic                      o_stop_end,
  output logic                      o_tx
);

  localparam int                c_baud_w   = $clog2(CLKS_PER_BIT);
  localparam logic [c_baud_w-1:0] c_baud_max = c_baud_w'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        c_last_bit = 3'(UART_DATA_BITS - 1);

  tx_state_t                 r_state;
  tx_state_t                 w_state_next;
  logic [c_baud_w-1:0]       r_baud;
  logic [c_baud_w-1:0]       w_baud_next;
  logic [2:0]                r_bit;
  logic [2:0]                w_bit_next;
  logic [UART_DATA_BITS-1:0] r_data;
  logic                      r_tx;
  logic                      w_tx_next;
  logic                      w_wrap;
  logic                      w_ready;
  logic                      w_accept;

  assign w_wrap     = (r_baud == c_baud_max);
  assign w_ready    = (r_state == ST_IDLE) || ((r_state == ST_STOP) && w_wrap);
  assign w_accept   = i_valid && w_ready;
  assign o_ready    = w_ready;
  assign o_stop_end = (r_state == ST_STOP) && w_wrap;
  assign o_tx       = r_tx;

  // State register plus the counters and line register it steers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_tx    <= UART_IDLE_LEVEL;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_tx    <= w_tx_next;
      if (w_accept) begin
        r_data <= i_data;
      end
    end
  end

  // Next-state and counter sequencing; everything advances on baud wrap only
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    case (r_state)
      ST_IDLE: begin
        w_baud_next = '0;
        w_bit_next  = '0;
        if (w_accept) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (w_wrap) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = ST_DATA;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      ST_DATA: begin
        if (w_wrap) begin
          w_baud_next = '0;
          if (r_bit == c_last_bit) begin
            w_bit_next   = '0;
            w_state_next = ST_STOP;
          end else begin
            w_bit_next = r_bit + 3'd1;
          end
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      ST_STOP: begin
        if (w_wrap) begin
          w_baud_next  = '0;
          w_bit_next   = '0;
          w_state_next = w_accept ? ST_START : ST_IDLE;
        end else begin
          w_baud_next = r_baud + 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_baud_next  = '0;
        w_bit_next   = '0;
      end
    endcase
  end

  // Line level is decoded from the next state so the registered TX_O changes
  // on the very edge that enters a state (start bit begins at the accept edge).
  always_comb begin
    w_tx_next = UART_IDLE_LEVEL;
    case (w_state_next)
      ST_START: w_tx_next = 1'b0;
      ST_DATA:  w_tx_next = r_data[w_bit_next];
      default:  w_tx_next = UART_IDLE_LEVEL;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fp32_result_uart_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : fp32_result_uart_tx                                           |
// | Description : Accepts one FP32 MAC result over valid/ready and sends it as |
// |               four back-to-back UART 8N1 frames.                           |
// | Ports       : CLK_I            - system clock, rising edge                 |
// |               RSTL_I           - synchronous active-low reset              |
// |               MAC_DELTA_I[31:0]- FP32 result from the MAC                  |
// |               MAC_VALID_I      - result valid                              |
// |               MAC_READY_O      - block can accept a result                 |
// |               TX_O             - UART serial line, idles high              |
// |               TX_BUSY_O        - a word is being serialised                |
// |               DONE_O           - one-cycle pulse after final stop bit      |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module fp32_result_uart_tx
  import fp32_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT   = 434,
  parameter bit MSB_BYTE_FIRST = 1'b1
) (
  input  logic        CLK_I,
  input  logic        RSTL_I,
  input  logic [31:0] MAC_DELTA_I,
  input  logic        MAC_VALID_I,
  output logic        MAC_READY_O,
  output logic        TX_O,
  output logic        TX_BUSY_O,
  output logic        DONE_O
);

  localparam logic [1:0] c_last_byte = 2'(BYTES_PER_WORD - 1);

  logic [31:0]               r_hold;
  logic [1:0]                r_byte_idx;
  logic                      r_ready;
  logic                      r_busy;
  logic                      r_done;
  logic                      w_word_accept;
  logic                      w_more_bytes;
  logic                      w_byte_valid;
  logic [UART_DATA_BITS-1:0] w_byte_data;
  logic                      w_byte_ready;
  logic                      w_stop_end;
  logic                      w_tx;

  assign w_word_accept = MAC_VALID_I && r_ready;
  assign w_more_bytes  = r_busy && (r_byte_idx != c_last_byte);
  assign w_byte_valid  = w_word_accept || w_more_bytes;

  // The first byte comes straight from the input bus so its start bit can
  // begin on the accept edge; later bytes come from the holding register.
  assign w_byte_data = w_word_accept
                     ? select_byte(MAC_DELTA_I, 2'd0, MSB_BYTE_FIRST)
                     : select_byte(r_hold, r_byte_idx + 2'd1, MSB_BYTE_FIRST);

  uart_byte_tx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_byte_tx (
    .i_clk      (CLK_I),
    .i_rst_n    (RSTL_I),
    .i_data     (w_byte_data),
    .i_valid    (w_byte_valid),
    .o_ready    (w_byte_ready),
    .o_stop_end (w_stop_end),
    .o_tx       (w_tx)
  );

  always_ff @(posedge CLK_I) begin
    if (!RSTL_I) begin
      r_hold     <= '0;
      r_byte_idx <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_word_accept) begin
        r_hold     <= MAC_DELTA_I;
        r_byte_idx <= '0;
        r_ready    <= 1'b0;
        r_busy     <= 1'b1;
      end else if (r_busy) begin
        if (w_byte_valid && w_byte_ready) begin
          r_byte_idx <= r_byte_idx + 2'd1;
        end else if (w_stop_end && (r_byte_idx == c_last_byte)) begin
          r_byte_idx <= '0;
          r_ready    <= 1'b1;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
        end
      end
    end
  end

  assign MAC_READY_O = r_ready;
  assign TX_BUSY_O   = r_busy;
  assign DONE_O      = r_done;
  assign TX_O        = w_tx;

endmodule
`default_nettype wire

// File: tb/tb_fp32_result_uart_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module      : tb_fp32_result_uart_tx                                        |
// | Description : Self-checking bench: two instances (MSB-first and LSB-first), |
// |               expected bytes queued at stimulus, UART line monitors decode  |
// |               frames and compare against the queues.                        |
// | Revision    : 1.0 - initial release                                         |
// +-----------------------------------------------------------------------------+
module tb_fp32_result_uart_tx;

  localparam int N = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstl;
  logic [31:0] dat_m, dat_l;
  logic        val_m, val_l;
  logic        rdy_m, rdy_l, tx_m, tx_l, bsy_m, bsy_l, done_m, done_l;

  fp32_result_uart_tx #(.CLKS_PER_BIT(N), .MSB_BYTE_FIRST(1'b1)) dut_m (
    .CLK_I(clk), .RSTL_I(rstl), .MAC_DELTA_I(dat_m), .MAC_VALID_I(val_m),
    .MAC_READY_O(rdy_m), .TX_O(tx_m), .TX_BUSY_O(bsy_m), .DONE_O(done_m));

  fp32_result_uart_tx #(.CLKS_PER_BIT(N), .MSB_BYTE_FIRST(1'b0)) dut_l (
    .CLK_I(clk), .RSTL_I(rstl), .MAC_DELTA_I(dat_l), .MAC_VALID_I(val_l),
    .MAC_READY_O(rdy_l), .TX_O(tx_l), .TX_BUSY_O(bsy_l), .DONE_O(done_l));

  int checks = 0;
  int errors = 0;
  int frames_m = 0;
  int frames_l = 0;
  logic [7:0] exp_m[$];
  logic [7:0] exp_l[$];
  logic cap_tx[0:511];
  logic cap_rdy[0:511];
  logic cap_bsy[0:511];
  logic cap_done[0:511];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] outs(input int which);
    if (which == 0) return {tx_m, rdy_m, bsy_m, done_m};
    return {tx_l, rdy_l, bsy_l, done_l};
  endfunction

  task automatic push1(input int which, input logic [7:0] b);
    if (which == 0) exp_m.push_back(b);
    else exp_l.push_back(b);
  endtask

  task automatic push4(input int which, input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    push1(which, b0); push1(which, b1); push1(which, b2); push1(which, b3);
  endtask

  // Called at #1 after a rising edge; returns at #1 after the transfer edge.
  task automatic accept(input int which, input logic [31:0] w);
    logic [3:0] o;
    int t;
    t = 0;
    if (which == 0) begin dat_m = w; val_m = 1'b1; end
    else begin dat_l = w; val_l = 1'b1; end
    o = outs(which);
    while (o[2] !== 1'b1 && t < 2000) begin
      @(posedge clk); #1;
      t++;
      o = outs(which);
    end
    if (t >= 2000) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic capture(input int which, input int n);
    for (int j = 0; j < n; j++) begin
      {cap_tx[j], cap_rdy[j], cap_bsy[j], cap_done[j]} = outs(which);
      @(posedge clk); #1;
    end
  endtask

  function automatic int first_done(input int n);
    for (int j = 0; j < n; j++) if (cap_done[j] === 1'b1) return j;
    return -1;
  endfunction

  function automatic int count_done(input int n);
    int c;
    c = 0;
    for (int j = 0; j < n; j++) if (cap_done[j] === 1'b1) c++;
    return c;
  endfunction

  function automatic int count_rdy_low(input int n);
    int c;
    c = 0;
    for (int j = 0; j < n; j++) if (cap_rdy[j] === 1'b0) c++;
    return c;
  endfunction

  function automatic int count_busy(input int n);
    int c;
    c = 0;
    for (int j = 0; j < n; j++) if (cap_bsy[j] !== 1'b0) c++;
    return c;
  endfunction

  // Line monitor: samples each bit mid-cell; frames interrupted by reset are dropped.
  task automatic monitor_line(input int which);
    logic [3:0] o;
    logic [7:0] b;
    logic [7:0] e;
    logic       st, sp;
    bit         abort;
    forever begin
      @(negedge clk);
      o = outs(which);
      if (rstl === 1'b1 && o[3] === 1'b0) begin
        abort = 1'b0; b = '0; st = 1'b1; sp = 1'b0;
        for (int c = 1; c <= 9 * N + N / 2; c++) begin
          @(negedge clk);
          o = outs(which);
          if (rstl !== 1'b1) abort = 1'b1;
          if (c % N == N / 2) begin
            if (c / N == 0) st = o[3];
            else if (c / N <= 8) b[3'(c / N - 1)] = o[3];
            else sp = o[3];
          end
        end
        if (!abort) begin
          check("start_bit_mid", {31'd0, st}, 32'd0);
          check("stop_bit_mid", {31'd0, sp}, 32'd1);
          if ((which == 0 && exp_m.size() == 0) || (which == 1 && exp_l.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte line=%0d actual=%0h expected=none", which, b);
          end else begin
            if (which == 0) e = exp_m.pop_front();
            else e = exp_l.pop_front();
            check(which == 0 ? "byte_msb_line" : "byte_lsb_line", {24'd0, b}, {24'd0, e});
          end
          if (which == 0) frames_m++;
          else frames_l++;
        end
      end
    end
  endtask

  initial monitor_line(0);
  initial monitor_line(1);

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog actual=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    int bad;
    rstl = 1'b0; val_m = 1'b0; val_l = 1'b0; dat_m = '0; dat_l = '0;
    repeat (3) @(posedge clk);
    #1;
    rstl = 1'b1;
    check("rst_tx_m", tx_m, 1);   check("rst_rdy_m", rdy_m, 1);
    check("rst_bsy_m", bsy_m, 0); check("rst_done_m", done_m, 0);
    check("rst_tx_l", tx_l, 1);   check("rst_rdy_l", rdy_l, 1);
    check("rst_bsy_l", bsy_l, 0); check("rst_done_l", done_l, 0);
    @(posedge clk); #1;

    // 1.5 MSB first, timing of start bit, ready and DONE_O
    push4(0, 8'h3F, 8'hC0, 8'h00, 8'h00);
    accept(0, 32'h3FC00000);
    val_m = 1'b0;
    check("t1_start_low", tx_m, 0);
    check("t1_ready_drop", rdy_m, 0);
    check("t1_busy_rise", bsy_m, 1);
    capture(0, 200);
    check("t1_done_pos", first_done(200), 160);
    check("t1_done_count", count_done(200), 1);
    check("t1_ready_low_span", count_rdy_low(160), 160);
    check("t1_ready_back", cap_rdy[160], 1);
    check("t1_busy_clear", cap_bsy[160], 0);
    check("t1_start_end", cap_tx[N-1], 0);
    check("t1_bit0", cap_tx[N], 1);

    // Back-to-back words with valid held high
    push4(0, 8'h40, 8'h49, 8'h0F, 8'hDB);
    push4(0, 8'hC0, 8'h00, 8'h00, 8'h00);
    accept(0, 32'h40490FDB);
    dat_m = 32'hC0000000;
    capture(0, 170);
    val_m = 1'b0;
    check("t2_done1_pos", first_done(170), 160);
    check("t2_second_start", cap_tx[161], 0);
    check("t2_second_rdy", cap_rdy[161], 0);
    check("t2_second_busy", cap_bsy[161], 1);
    capture(0, 200);
    check("t2_done2_pos", first_done(200), 151);
    check("t2_done2_count", count_done(200), 1);

    // Input changes while busy are ignored
    push4(0, 8'hA5, 8'hA5, 8'h5A, 8'h5A);
    accept(0, 32'hA5A55A5A);
    dat_m = 32'hFFFFFFFF;
    capture(0, 100);
    check("t3_no_early_done", count_done(100), 0);
    check("t3_ready_low", count_rdy_low(100), 100);
    val_m = 1'b0;
    capture(0, 300);
    check("t3_done_pos", first_done(300), 60);
    check("t3_done_count", count_done(300), 1);

    // LSB-first byte order
    push4(1, 8'h78, 8'h56, 8'h34, 8'h12);
    accept(1, 32'h12345678);
    val_l = 1'b0;
    capture(1, 200);
    check("t4_done_pos", first_done(200), 160);
    check("t4_b0_bit0", cap_tx[N], 0);
    check("t4_b0_bit3", cap_tx[4*N], 1);
    check("t4_b1_bit1", cap_tx[10*N + 2*N], 1);

    // Reset during data of byte 2
    push1(0, 8'h11);
    push1(0, 8'h22);
    accept(0, 32'h11223344);
    val_m = 1'b0;
    capture(0, 90);
    rstl = 1'b0;
    @(posedge clk); #1;
    check("t5_tx_high", tx_m, 1);
    check("t5_ready_high", rdy_m, 1);
    check("t5_busy_low", bsy_m, 0);
    check("t5_done_low", done_m, 0);
    rstl = 1'b1;
    capture(0, 300);
    check("t5_no_done", count_done(300), 0);
    check("t5_stays_idle", count_busy(300), 0);
    push4(0, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    accept(0, 32'hDEADBEEF);
    val_m = 1'b0;
    capture(0, 200);
    check("t5_next_done_pos", first_done(200), 160);

    // Idle line after reset
    rstl = 1'b0;
    @(posedge clk); #1;
    rstl = 1'b1;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      if (tx_m !== 1'b1 || bsy_m !== 1'b0 || tx_l !== 1'b1 || bsy_l !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    check("t6_idle_quiet", bad, 0);

    repeat (50) @(posedge clk);
    #1;
    check("exp_m_drained", exp_m.size(), 0);
    check("exp_l_drained", exp_l.size(), 0);
    check("frames_m", frames_m, 22);
    check("frames_l", frames_l, 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
